// File: rtl/dual_port_ram_sync_be_if.sv
// Bus bundle for dual_port_ram_sync_be: clear request/status, the byte-enabled
// write port and the read port. The master side (user) drives requests; the
// slave side (RAM) returns busy and read results.
interface dual_port_ram_sync_be_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDRESS_SIZE = 3
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                    clr;
  logic                    busy;
  logic                    we;
  logic [ADDRESS_SIZE-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NUM_BYTES-1:0]    wr_be;
  logic                    re;
  logic [ADDRESS_SIZE-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;

  modport master (
    output clr, we, wr_addr, wr_data, wr_be, re, rd_addr,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clr, we, wr_addr, wr_data, wr_be, re, rd_addr,
    output busy, rd_data, rd_valid
  );
endinterface

// File: rtl/dual_port_ram_sync_be.sv
// Simple dual-port RAM, single clock: one byte-enabled write port, one read
// port with 1- or 2-cycle latency, selectable read-during-write behaviour and
// a sequenced clear engine that zeroes one word per cycle while busy is high.
module dual_port_ram_sync_be #(
  parameter int DATA_WIDTH    = 16,
  parameter int BYTE_WIDTH    = 8,
  parameter int ADDRESS_SIZE  = 3,
  parameter int ADDRESS_DEPTH = 8,
  parameter int RD_LATENCY    = 1,
  parameter int RDW_MODE      = 0
) (
  input logic                    clk,
  input logic                    rst,
  dual_port_ram_sync_be_if.slave bus
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  // Depth widened by one bit so the range compare never truncates.
  localparam logic [ADDRESS_SIZE:0]   DEPTH_W  = (ADDRESS_SIZE+1)'(ADDRESS_DEPTH);
  localparam logic [ADDRESS_SIZE-1:0] LAST_PTR = ADDRESS_SIZE'(ADDRESS_DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDRESS_SIZE-1:0] clr_ptr_r, clr_ptr_s;
  logic                    busy_r, busy_s;
  logic                    clear_we_s;

  logic [DATA_WIDTH-1:0]   mem_r [0:ADDRESS_DEPTH-1];

  logic                    wr_ok_s;
  logic                    rd_ok_s;
  logic                    rd_in_range_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;

  logic                    s1_valid_r;
  logic [DATA_WIDTH-1:0]   s1_data_r;

  // Accesses are only honoured while idle; out-of-range writes are dropped.
  assign wr_ok_s       = (state_r == IDLE) && bus.we && ({1'b0, bus.wr_addr} < DEPTH_W);
  assign rd_ok_s       = (state_r == IDLE) && bus.re;
  assign rd_in_range_s = ({1'b0, bus.rd_addr} < DEPTH_W);
  assign bus.busy      = busy_r;

  // Clear FSM next-state: a clr request arms the engine, which then walks every address once.
  always_comb begin
    state_s    = state_r;
    clr_ptr_s  = clr_ptr_r;
    busy_s     = busy_r;
    clear_we_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.clr) begin
          state_s   = CLEAR;
          clr_ptr_s = '0;
          busy_s    = 1'b1;
        end else begin
          busy_s    = 1'b0;
        end
      end
      CLEAR: begin
        clear_we_s = 1'b1;
        if (clr_ptr_r == LAST_PTR) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          clr_ptr_s = clr_ptr_r + 1'b1;
        end
      end
      default: begin
        state_s   = CLEAR;
        clr_ptr_s = '0;
        busy_s    = 1'b1;
      end
    endcase
  end

  // Clear FSM state register; reset always restarts a full clear from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_ptr_r <= '0;
      busy_r    <= 1'b1;
    end else begin
      state_r   <= state_s;
      clr_ptr_r <= clr_ptr_s;
      busy_r    <= busy_s;
    end
  end

  // Memory array update: clear engine zeroes one word, otherwise enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_we_s) begin
        mem_r[clr_ptr_r] <= '0;
      end else if (wr_ok_s) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (bus.wr_be[i]) begin
            mem_r[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Read word selection: zero when out of range, optional byte-merged bypass on a same-address write.
  always_comb begin
    rd_word_s = '0;
    if (rd_in_range_s) begin
      rd_word_s = mem_r[bus.rd_addr];
      if ((RDW_MODE == 1) && wr_ok_s && (bus.wr_addr == bus.rd_addr)) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (bus.wr_be[i]) begin
            rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end else begin
            rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_r[bus.rd_addr][i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end else begin
        rd_word_s = mem_r[bus.rd_addr];
      end
    end else begin
      rd_word_s = '0;
    end
  end

  // First read stage: captures the word on the accepting edge; data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
    end else begin
      s1_valid_r <= rd_ok_s;
      if (rd_ok_s) begin
        s1_data_r <= rd_word_s;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  out_valid_r;
      logic [DATA_WIDTH-1:0] out_data_r;

      // Extra output register stage for the two-cycle read latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_r <= 1'b0;
          out_data_r  <= '0;
        end else begin
          out_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            out_data_r <= s1_data_r;
          end
        end
      end

      assign bus.rd_valid = out_valid_r;
      assign bus.rd_data  = out_data_r;
    end else begin : g_lat1
      assign bus.rd_valid = s1_valid_r;
      assign bus.rd_data  = s1_data_r;
    end
  endgenerate
endmodule

// File: tb/tb_dual_port_ram_sync_be.sv
// Directed bench for dual_port_ram_sync_be. Instance A: latency 1, old-data
// collisions; instance B: latency 2, new-data collisions (A and B share
// stimulus); instance C: depth 6 for out-of-range handling.
module tb_dual_port_ram_sync_be;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dual_port_ram_sync_be_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDRESS_SIZE(3)) a_if ();
  dual_port_ram_sync_be_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDRESS_SIZE(3)) b_if ();
  dual_port_ram_sync_be_if #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDRESS_SIZE(3)) c_if ();

  dual_port_ram_sync_be #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDRESS_SIZE(3), .ADDRESS_DEPTH(8),
                          .RD_LATENCY(1), .RDW_MODE(0)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  dual_port_ram_sync_be #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDRESS_SIZE(3), .ADDRESS_DEPTH(8),
                          .RD_LATENCY(2), .RDW_MODE(1)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  dual_port_ram_sync_be #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDRESS_SIZE(3), .ADDRESS_DEPTH(6),
                          .RD_LATENCY(1), .RDW_MODE(0)) u_c (.clk(clk), .rst(rst), .bus(c_if));

  // Shared stimulus for A and B
  logic        clr_d = 1'b0, we_d = 1'b0, re_d = 1'b0;
  logic [2:0]  wa_d = 3'd0, ra_d = 3'd0;
  logic [15:0] wd_d = 16'h0000;
  logic [1:0]  be_d = 2'b00;
  // Stimulus for C
  logic        c_we = 1'b0, c_re = 1'b0;
  logic [2:0]  c_wa = 3'd0, c_ra = 3'd0;
  logic [15:0] c_wd = 16'h0000;

  assign a_if.clr = clr_d;  assign a_if.we = we_d;  assign a_if.re = re_d;
  assign a_if.wr_addr = wa_d; assign a_if.rd_addr = ra_d;
  assign a_if.wr_data = wd_d; assign a_if.wr_be = be_d;
  assign b_if.clr = clr_d;  assign b_if.we = we_d;  assign b_if.re = re_d;
  assign b_if.wr_addr = wa_d; assign b_if.rd_addr = ra_d;
  assign b_if.wr_data = wd_d; assign b_if.wr_be = be_d;
  assign c_if.clr = 1'b0;   assign c_if.we = c_we;  assign c_if.re = c_re;
  assign c_if.wr_addr = c_wa; assign c_if.rd_addr = c_ra;
  assign c_if.wr_data = c_wd; assign c_if.wr_be = 2'b11;

  int num_checks = 0;
  int num_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ab(input logic [2:0] addr, input logic [15:0] data, input logic [1:0] be);
    we_d = 1'b1; wa_d = addr; wd_d = data; be_d = be;
    step();
    we_d = 1'b0;
  endtask

  // One read on A and B; A answers after one edge, B after two.
  task automatic read_ab(input string tag, input logic [2:0] addr,
                         input logic [15:0] exp_a, input logic [15:0] exp_b);
    re_d = 1'b1; ra_d = addr;
    step();
    re_d = 1'b0;
    chk({tag, "_a_valid"}, a_if.rd_valid, 1);
    chk({tag, "_a_data"}, a_if.rd_data, exp_a);
    chk({tag, "_b_early"}, b_if.rd_valid, 0);
    step();
    chk({tag, "_a_pulse"}, a_if.rd_valid, 0);
    chk({tag, "_b_valid"}, b_if.rd_valid, 1);
    chk({tag, "_b_data"}, b_if.rd_data, exp_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int na, nb, nc, e, seen;

    // Reset held for two edges
    step();
    chk("rst_busy_a", a_if.busy, 1);
    chk("rst_valid_a", a_if.rd_valid, 0);
    chk("rst_data_a", a_if.rd_data, 0);
    chk("rst_data_b", b_if.rd_data, 0);
    chk("rst_busy_c", c_if.busy, 1);
    step();
    rst = 1'b0;
    na = 0; nb = 0; nc = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (!a_if.busy && na == 0) na = k;
      if (!b_if.busy && nb == 0) nb = k;
      if (!c_if.busy && nc == 0) nc = k;
    end
    chk("init_clear_len_a", na, 8);
    chk("init_clear_len_b", nb, 8);
    chk("init_clear_len_c", nc, 6);
    for (int i = 0; i < 8; i++) read_ab("zero", 3'(i), 16'h0000, 16'h0000);

    // Byte enables
    write_ab(3'd3, 16'hA5A5, 2'b11);
    write_ab(3'd3, 16'h1234, 2'b01);
    read_ab("be", 3'd3, 16'hA534, 16'hA534);
    write_ab(3'd4, 16'h4444, 2'b11);
    write_ab(3'd5, 16'h5555, 2'b11);

    // Back-to-back reads of 3,4,5
    re_d = 1'b1; ra_d = 3'd3;
    step();
    chk("b2b1_a_v", a_if.rd_valid, 1); chk("b2b1_a_d", a_if.rd_data, 16'hA534);
    chk("b2b1_b_v", b_if.rd_valid, 0);
    ra_d = 3'd4;
    step();
    chk("b2b2_a_v", a_if.rd_valid, 1); chk("b2b2_a_d", a_if.rd_data, 16'h4444);
    chk("b2b2_b_v", b_if.rd_valid, 1); chk("b2b2_b_d", b_if.rd_data, 16'hA534);
    ra_d = 3'd5;
    step();
    chk("b2b3_a_v", a_if.rd_valid, 1); chk("b2b3_a_d", a_if.rd_data, 16'h5555);
    chk("b2b3_b_v", b_if.rd_valid, 1); chk("b2b3_b_d", b_if.rd_data, 16'h4444);
    re_d = 1'b0;
    step();
    chk("b2b4_a_v", a_if.rd_valid, 0); chk("b2b4_a_hold", a_if.rd_data, 16'h5555);
    chk("b2b4_b_v", b_if.rd_valid, 1); chk("b2b4_b_d", b_if.rd_data, 16'h5555);
    step();
    chk("b2b5_b_v", b_if.rd_valid, 0);

    // Read-during-write collisions
    write_ab(3'd2, 16'h1111, 2'b11);
    we_d = 1'b1; wa_d = 3'd2; wd_d = 16'h2222; be_d = 2'b11; re_d = 1'b1; ra_d = 3'd2;
    step();
    we_d = 1'b0; re_d = 1'b0;
    chk("rdw_full_a", a_if.rd_data, 16'h1111);
    step();
    chk("rdw_full_b", b_if.rd_data, 16'h2222);
    read_ab("rdw_after", 3'd2, 16'h2222, 16'h2222);
    we_d = 1'b1; wa_d = 3'd2; wd_d = 16'h3399; be_d = 2'b01; re_d = 1'b1; ra_d = 3'd2;
    step();
    we_d = 1'b0; re_d = 1'b0;
    chk("rdw_part_a", a_if.rd_data, 16'h2222);
    step();
    chk("rdw_part_b", b_if.rd_data, 16'h2299);
    read_ab("rdw_part_after", 3'd2, 16'h2299, 16'h2299);

    // Clear blocks accesses; a clr pulse mid-clear is ignored
    write_ab(3'd1, 16'h7777, 2'b11);
    clr_d = 1'b1;
    step();
    clr_d = 1'b0;
    chk("clr_busy_a", a_if.busy, 1);
    we_d = 1'b1; wa_d = 3'd1; wd_d = 16'hBEEF; be_d = 2'b11; re_d = 1'b1; ra_d = 3'd1;
    e = 0; seen = 0;
    while (a_if.busy && e < 20) begin
      clr_d = (e == 2);
      step();
      e++;
      if (a_if.rd_valid || b_if.rd_valid) seen = 1;
    end
    we_d = 1'b0; re_d = 1'b0; clr_d = 1'b0;
    chk("clr_len", e, 8);
    chk("busy_no_valid", seen, 0);
    read_ab("blocked_wr", 3'd1, 16'h0000, 16'h0000);
    read_ab("cleared", 3'd3, 16'h0000, 16'h0000);

    // Reset at clr_ptr=5 restarts the clear
    write_ab(3'd7, 16'h7777, 2'b11);
    clr_d = 1'b1;
    step();
    clr_d = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", a_if.busy, 1);
    chk("midrst_data", a_if.rd_data, 0);
    e = 0;
    while (a_if.busy && e < 20) begin
      step();
      e++;
    end
    chk("midrst_len", e, 8);
    read_ab("midrst_addr7", 3'd7, 16'h0000, 16'h0000);

    // Depth-6 instance: in-range write/read, out-of-range write dropped and read returns 0
    chk("c_idle", c_if.busy, 0);
    c_we = 1'b1; c_wa = 3'd5; c_wd = 16'h5A5A;
    step();
    c_wa = 3'd7; c_wd = 16'hDEAD;
    step();
    c_we = 1'b0; c_re = 1'b1; c_ra = 3'd5;
    step();
    chk("c_in_v", c_if.rd_valid, 1); chk("c_in_d", c_if.rd_data, 16'h5A5A);
    c_ra = 3'd7;
    step();
    c_re = 1'b0;
    chk("c_oor_v", c_if.rd_valid, 1); chk("c_oor_d", c_if.rd_data, 16'h0000);
    c_re = 1'b1; c_ra = 3'd0;
    step();
    c_re = 1'b0;
    chk("c_addr0_d", c_if.rd_data, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end
endmodule
